// File: rtl/ps2_key_event_queue_pkg.sv
// Shared scancode constants, direction codes and decoder state encoding
// for the PS/2 key event queue.
package ps2_key_event_queue_pkg;

  localparam int EVT_W = 10;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } dec_state_t;

  // Keyboard housekeeping bytes (BAT ok, ACK, resend, echo, errors).
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic [2:0] dir_decode(input logic ext, input logic [7:0] code);
    logic [2:0] d;
    d = DIR_NONE;
    if (ext) begin
      if (code == SC_UP)         d = DIR_UP;
      else if (code == SC_DOWN)  d = DIR_DOWN;
      else if (code == SC_LEFT)  d = DIR_LEFT;
      else if (code == SC_RIGHT) d = DIR_RIGHT;
    end else begin
      if (code == SC_W)          d = DIR_UP;
      else if (code == SC_S)     d = DIR_DOWN;
      else if (code == SC_A)     d = DIR_LEFT;
      else if (code == SC_D)     d = DIR_RIGHT;
    end
    return d;
  endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Byte-in / event-out bus of the key event queue.
interface ps2_key_event_queue_if #(parameter int PTR_W = 2);
  logic             key_valid;
  logic [7:0]       key_byte;
  logic             pop;
  logic             clear;
  logic             evt_valid;
  logic [9:0]       evt_data;
  logic [2:0]       evt_dir;
  logic [PTR_W:0]   count;
  logic             overflow;

  modport master (
    output key_valid, key_byte, pop, clear,
    input  evt_valid, evt_data, evt_dir, count, overflow
  );

  modport slave (
    input  key_valid, key_byte, pop, clear,
    output evt_valid, evt_data, evt_dir, count, overflow
  );
endinterface

// File: rtl/ps2_key_event_queue_evt_fifo.sv
// Show-ahead event FIFO with explicit occupancy count; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [PTR_W:0]   o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Storage is not reset, so an empty FIFO presents zero instead of stale data.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scancode prefix decoder, typematic repeat filter and direction decode
// feeding a small show-ahead event FIFO.
//   state     | meaning
//   ST_IDLE   | no prefix pending
//   ST_EXT    | E0 seen
//   ST_BRK    | F0 seen
//   ST_EXTBRK | E0 F0 seen
module ps2_key_event_queue
  import ps2_key_event_queue_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int PTR_W         = 2,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  ps2_key_event_queue_if.slave    bus
);
  dec_state_t  r_state;
  dec_state_t  w_state_nxt;
  logic        w_emit;
  logic        w_rel;
  logic        w_ext;
  logic [8:0]  w_key;
  logic        w_match;
  logic        w_push;
  logic [8:0]  r_last_make;
  logic        r_overflow;
  logic        w_full;
  logic        w_empty;
  logic [EVT_W-1:0] w_head;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)        r_state <= ST_IDLE;
    else if (bus.clear) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_rel       = 1'b0;
    w_ext       = 1'b0;
    if (bus.key_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.key_byte == SC_EXT)      w_state_nxt = ST_EXT;
          else if (bus.key_byte == SC_BRK) w_state_nxt = ST_BRK;
          else if (!is_ignored(bus.key_byte)) w_emit = 1'b1;
        end
        ST_EXT: begin
          if (bus.key_byte == SC_BRK) w_state_nxt = ST_EXTBRK;
          else if (bus.key_byte != SC_EXT) begin
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          // A stray E0 after F0 restarts as an extended sequence.
          if (bus.key_byte == SC_EXT) w_state_nxt = ST_EXT;
          else if (bus.key_byte != SC_BRK) begin
            w_emit      = 1'b1;
            w_rel       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXTBRK: begin
          if ((bus.key_byte != SC_EXT) && (bus.key_byte != SC_BRK)) begin
            w_emit      = 1'b1;
            w_rel       = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_key   = {w_ext, bus.key_byte};
  assign w_match = (w_key == r_last_make);
  assign w_push  = w_emit && !(!w_rel && (REPEAT_FILTER != 0) && w_match);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_last_make <= '0;
      r_overflow  <= 1'b0;
    end else if (bus.clear) begin
      r_last_make <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push && !w_rel)              r_last_make <= w_key;
      else if (w_emit && w_rel && w_match) r_last_make <= '0;
      if (w_push && w_full && !bus.pop)  r_overflow  <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_pop   (bus.pop),
    .i_clear (bus.clear),
    .i_wdata ({w_rel, w_ext, bus.key_byte}),
    .o_rdata (w_head),
    .o_count (bus.count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.evt_valid = !w_empty;
  assign bus.evt_data  = w_head;
  assign bus.evt_dir   = dir_decode(w_head[8], w_head[7:0]);
  assign bus.overflow  = r_overflow;
endmodule
